// File: rtl/buffer_mux_n.sv
// buffer_mux_n: N-channel valid/ready multiplexer feeding an output FIFO.
// One channel is granted per cycle, either by an external selector (fixed
// mode) or by a round-robin arbiter. Words from the granted channel are queued
// in a FIFO_DEPTH-entry FIFO whose head drives the single downstream port.
// in_ready depends only on registered state (and rst), so there is no
// combinational path from in_valid or out_ready back to the producers.
module buffer_mux_n #(
    parameter int DATA_WIDTH = 40,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [SEL_WIDTH-1:0]         selector,
    input  logic                         rr_mode,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_WIDTH-1:0]         count
);

    // Pointers index FIFO_DEPTH (a power of two) entries, so they wrap
    // naturally; the occupancy counter needs one extra bit to represent "full".
    localparam int                   PTR_WIDTH  = CNT_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SEL_WIDTH-1:0]  grant_q,  grant_d;
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Derived status
    // ------------------------------------------------------------------
    logic                  full;
    logic                  empty;
    logic                  gnt_valid;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  push;
    logic                  pop;
    logic [SEL_WIDTH-1:0]  rr_next;
    int                    rr_dist;
    int                    rr_best;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Select the valid bit and data word of the currently granted channel.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the loop can leave it unassigned and infer a latch.
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == SEL_WIDTH'(i)) begin
                gnt_valid = in_valid[i];
                gnt_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A word transfers in when the granted channel offers one and there is
    // room; a full FIFO refuses even when a pop happens in the same cycle.
    assign push = gnt_valid && !full;
    assign pop  = !empty && out_ready;

    // Only the granted channel sees ready, and only while the FIFO has room.
    // Held low during reset so producers never see a spurious accept.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = !rst && !full && (grant_q == SEL_WIDTH'(i));
        end
    end

    // ------------------------------------------------------------------
    // Output port
    // ------------------------------------------------------------------
    assign out_valid = !empty;
    assign count     = count_q;
    // Head word, forced to zero while empty so stale entries never leak out.
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    // Pick the valid channel closest after the current grant, wrapping around;
    // the current grant itself has the largest distance so it is tried last.
    // If nothing is valid the grant stays where it is.
    always_comb begin
        rr_next = grant_q;
        rr_best = NUM_CH + 1;
        rr_dist = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_dist = i - int'(grant_q);
            if (rr_dist <= 0) begin
                rr_dist = rr_dist + NUM_CH;
            end
            if (in_valid[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_next = SEL_WIDTH'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Grant update: follow an in-range selector in fixed mode; in round-robin
    // mode move on after a transfer or when the granted channel is idle.
    always_comb begin
        grant_d = grant_q;
        if (rr_mode) begin
            if (push || !gnt_valid) begin
                grant_d = rr_next;
            end
        end else if (int'(selector) < NUM_CH) begin
            grant_d = selector;
        end
    end

    // FIFO pointer and occupancy update; simultaneous push and pop leaves
    // the count unchanged while both pointers advance.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Control state with asynchronous reset; reset empties the FIFO logically.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            grant_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            grant_q  <= grant_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: write the granted word at the tail on a push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; a zero count
        // already marks every entry invalid and out_data is masked when empty,
        // so resetting it would only add reset fan-out to a RAM-like array.
        if (push) begin
            mem_q[wr_ptr_q] <= gnt_data;
        end
    end

endmodule

// File: tb/tb_buffer_mux_n.sv
// tb_buffer_mux_n: self-checking bench for buffer_mux_n. Two instances are
// exercised: the default 4-channel build and a 3-channel build whose 2-bit
// selector can name a non-existent channel. A queue-based reference model
// tracks each FIFO and its grant; outputs are compared every cycle.
module tb_buffer_mux_n;

    localparam int DW    = 40;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance signals
    logic [4*DW-1:0] in_data4;
    logic [3:0]      in_valid4;
    logic [3:0]      in_ready4;
    logic [SW-1:0]   selector4;
    logic            rr_mode4;
    logic [DW-1:0]   out_data4;
    logic            out_valid4;
    logic            out_ready4;
    logic [CW-1:0]   count4;
    logic [DW-1:0]   ch4 [4];

    // 3-channel instance signals
    logic [3*DW-1:0] in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic [SW-1:0]   selector3;
    logic            rr_mode3;
    logic [DW-1:0]   out_data3;
    logic            out_valid3;
    logic            out_ready3;
    logic [CW-1:0]   count3;
    logic [DW-1:0]   ch3 [3];

    always_comb begin
        in_data4 = '0;
        for (int i = 0; i < 4; i++) in_data4[i*DW +: DW] = ch4[i];
    end

    always_comb begin
        in_data3 = '0;
        for (int i = 0; i < 3; i++) in_data3[i*DW +: DW] = ch3[i];
    end

    buffer_mux_n #(.DATA_WIDTH(DW), .NUM_CH(4), .SEL_WIDTH(SW),
                   .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .selector  (selector4),
        .rr_mode   (rr_mode4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .count     (count4)
    );

    buffer_mux_n #(.DATA_WIDTH(DW), .NUM_CH(3), .SEL_WIDTH(SW),
                   .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .selector  (selector3),
        .rr_mode   (rr_mode3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .count     (count3)
    );

    // Reference model state
    logic [DW-1:0] q4 [$];
    logic [DW-1:0] q3 [$];
    logic [DW-1:0] pop_log4 [$];
    logic [DW-1:0] pop_log3 [$];
    int            g4;
    int            g3;
    int            pushed4 [4];
    int            pushed3 [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ready_exp(input int g, input int qsize);
        return (qsize < DEPTH) ? (16'(1) << g) : 16'h0;
    endfunction

    // Rules of the multiplexer applied to one clock edge.
    task automatic model_step(input int nch, input int g, input int qsize, input int vld,
                              input bit ordy, input bit rr, input int sel,
                              output bit push, output bit pop, output int g_next);
        bit gv;
        gv     = ((vld >> g) & 1) != 0;
        push   = gv && (qsize < DEPTH);
        pop    = (qsize > 0) && ordy;
        g_next = g;
        if (rr) begin
            if (push || !gv) begin
                for (int k = 1; k <= nch; k++) begin
                    int c;
                    c = (g + k) % nch;
                    if (((vld >> c) & 1) != 0) begin
                        g_next = c;
                        break;
                    end
                end
            end
        end else if (sel < nch) begin
            g_next = sel;
        end
    endtask

    // Compare both instances against the model, then advance one clock.
    task automatic cycle();
        bit push4, pop4, push3, pop3;
        int gn4, gn3;
        logic [DW-1:0] d4, d3;
        #1;
        check("ready4", 64'(in_ready4), 64'(ready_exp(g4, q4.size())));
        check("valid4", 64'(out_valid4), 64'(q4.size() > 0));
        check("data4",  64'(out_data4), (q4.size() > 0) ? 64'(q4[0]) : 64'h0);
        check("count4", 64'(count4), 64'(q4.size()));
        check("ready3", 64'(in_ready3), 64'(ready_exp(g3, q3.size())));
        check("valid3", 64'(out_valid3), 64'(q3.size() > 0));
        check("data3",  64'(out_data3), (q3.size() > 0) ? 64'(q3[0]) : 64'h0);
        check("count3", 64'(count3), 64'(q3.size()));
        model_step(4, g4, q4.size(), int'(in_valid4), out_ready4, rr_mode4, int'(selector4),
                   push4, pop4, gn4);
        model_step(3, g3, q3.size(), int'(in_valid3), out_ready3, rr_mode3, int'(selector3),
                   push3, pop3, gn3);
        d4 = ch4[g4];
        d3 = ch3[g3];
        @(posedge clk);
        #1;
        if (pop4) pop_log4.push_back(q4.pop_front());
        if (push4) begin
            q4.push_back(d4);
            pushed4[g4]++;
        end
        g4 = gn4;
        if (pop3) pop_log3.push_back(q3.pop_front());
        if (push3) begin
            q3.push_back(d3);
            pushed3[g3]++;
        end
        g3 = gn3;
    endtask

    // Assert reset between clock edges, check the immediate effect, release.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_count4", 64'(count4), 64'h0);
        check("rst_valid4", 64'(out_valid4), 64'h0);
        check("rst_data4",  64'(out_data4), 64'h0);
        check("rst_ready4", 64'(in_ready4), 64'h0);
        check("rst_count3", 64'(count3), 64'h0);
        check("rst_ready3", 64'(in_ready3), 64'h0);
        q4.delete();
        q3.delete();
        g4 = 0;
        g3 = 0;
        for (int i = 0; i < 4; i++) pushed4[i] = 0;
        for (int i = 0; i < 3; i++) pushed3[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready4", 64'(in_ready4), 64'h1);
        check("rel_ready3", 64'(in_ready3), 64'h1);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {8'($urandom), $urandom};
    endfunction

    initial begin
        logic [DW-1:0] w, w_prev;
        in_valid4 = '0; selector4 = '0; rr_mode4 = 1'b0; out_ready4 = 1'b0;
        in_valid3 = '0; selector3 = '0; rr_mode3 = 1'b0; out_ready3 = 1'b0;
        for (int i = 0; i < 4; i++) ch4[i] = rnd_word();
        for (int i = 0; i < 3; i++) ch3[i] = rnd_word();
        do_reset();

        // Reset mid-stream with three words queued.
        in_valid4 = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            cycle();
            ch4[0] = rnd_word();
        end
        check("pre_rst_count", 64'(count4), 64'd3);
        do_reset();

        // Fixed mode on channel 2: fill, then drain in order.
        selector4 = 2'd2;
        in_valid4 = 4'b0000;
        cycle();
        in_valid4 = 4'b1111;
        ch4[2] = 40'hA0;
        for (int n = 0; n < 8 && pushed4[2] < 4; n++) begin
            cycle();
            ch4[2] = 40'hA0 + DW'(pushed4[2]);
            for (int i = 0; i < 4; i++) if (i != 2) ch4[i] = rnd_word();
        end
        check("fix_full_count", 64'(count4), 64'd4);
        check("fix_full_ready", 64'(in_ready4), 64'h0);
        cycle();
        pop_log4.delete();
        out_ready4 = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (pushed4[2] >= 6) in_valid4 = 4'b0000;
            cycle();
            ch4[2] = 40'hA0 + DW'(pushed4[2]);
        end
        check("fix_pop_count", 64'(pop_log4.size()), 64'd6);
        for (int k = 0; k < pop_log4.size(); k++) begin
            check("fix_order", 64'(pop_log4[k]), 64'hA0 + 64'(k));
        end

        // Round-robin with every channel requesting.
        do_reset();
        rr_mode4   = 1'b1;
        in_valid4  = 4'b1111;
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) ch4[i] = DW'(16 * i);
        pop_log4.delete();
        for (int n = 0; n < 12; n++) begin
            cycle();
            for (int i = 0; i < 4; i++) ch4[i] = DW'(16 * i + pushed4[i]);
        end
        check("rr_rate", 64'(pop_log4.size()), 64'd11);
        for (int k = 0; k < pop_log4.size(); k++) begin
            check("rr_order", 64'(pop_log4[k]), 64'(16 * (k % 4) + k / 4));
        end

        // Round-robin with only channels 1 and 3 requesting.
        in_valid4 = 4'b0000;
        for (int n = 0; n < 3; n++) cycle();
        pop_log4.delete();
        in_valid4 = 4'b1010;
        for (int n = 0; n < 9; n++) begin
            cycle();
            check("skip_ready", 64'(in_ready4 & 4'b0101), 64'h0);
            for (int i = 0; i < 4; i++) ch4[i] = DW'(16 * i + pushed4[i]);
        end
        check("skip_pops", 64'(pop_log4.size() >= 6), 64'h1);
        for (int k = 0; k < pop_log4.size(); k++) begin
            w = pop_log4[k];
            check("skip_ch", 64'((w[7:4] == 4'd1) || (w[7:4] == 4'd3)), 64'h1);
            if (k > 0) begin
                w_prev = pop_log4[k-1];
                check("skip_alt", 64'(w[7:4] != w_prev[7:4]), 64'h1);
            end
        end

        // Full boundary: pop without push, then refill on the next edge.
        rr_mode4   = 1'b0;
        selector4  = 2'd0;
        in_valid4  = 4'b0000;
        out_ready4 = 1'b1;
        for (int n = 0; n < 3; n++) cycle();
        out_ready4 = 1'b0;
        in_valid4  = 4'b0001;
        for (int n = 0; n < 8 && q4.size() < DEPTH; n++) begin
            cycle();
            ch4[0] = rnd_word();
        end
        check("full_count", 64'(count4), 64'd4);
        out_ready4 = 1'b1;
        cycle();
        check("full_pop_only", 64'(count4), 64'd3);
        out_ready4 = 1'b0;
        cycle();
        check("full_refill", 64'(count4), 64'd4);

        // Pointer wrap in the 3-channel build with an out-of-range selector.
        in_valid4  = 4'b0000;
        out_ready4 = 1'b1;
        selector3  = 2'd1;
        cycle();
        selector3  = 2'd3;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        pop_log3.delete();
        ch3[1] = 40'hB0 + DW'(pushed3[1]);
        for (int n = 0; n < 11; n++) begin
            if (pushed3[1] >= 10) in_valid3 = 3'b000;
            cycle();
            check("wrap_grant", 64'(in_ready3), 64'b010);
            ch3[1] = 40'hB0 + DW'(pushed3[1]);
            ch3[0] = rnd_word();
            ch3[2] = rnd_word();
        end
        check("wrap_pops", 64'(pop_log3.size()), 64'd10);
        for (int k = 0; k < pop_log3.size(); k++) begin
            check("wrap_order", 64'(pop_log3[k]), 64'hB0 + 64'(k));
        end

        // Randomized traffic on both instances, including mode switches.
        for (int n = 0; n < 400; n++) begin
            in_valid4  = 4'($urandom);
            out_ready4 = 1'($urandom_range(0, 3) != 0);
            selector4  = SW'($urandom);
            if ($urandom_range(0, 15) == 0) rr_mode4 = ~rr_mode4;
            in_valid3  = 3'($urandom);
            out_ready3 = 1'($urandom_range(0, 2) != 0);
            selector3  = SW'($urandom);
            if ($urandom_range(0, 15) == 0) rr_mode3 = ~rr_mode3;
            for (int i = 0; i < 4; i++) ch4[i] = rnd_word();
            for (int i = 0; i < 3; i++) ch3[i] = rnd_word();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_mux_n.md
# buffer_mux_n

Parametrised N-channel buffered multiplexer with valid/ready handshakes on every input channel and on the output. It accepts words from one granted channel per cycle, chosen either by an external selector or by a built-in round-robin arbiter, and queues them in an output FIFO. It sits between the packet producers (headers included in `DATA_WIDTH`) and the single downstream consumer. It replaces the fixed 4-input selector stage.

## Interface
- `DATA_WIDTH`, 40, word width including header bits
- `NUM_CH`, 4, number of input channels, 2..16
- `SEL_WIDTH`, 2, selector width; must equal clog2(`NUM_CH`)
- `FIFO_DEPTH`, 4, output FIFO entries, power of two, ≥2
- `CNT_WIDTH`, 3, occupancy width; must equal clog2(`FIFO_DEPTH`)+1

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_data` in `NUM_CH*DATA_WIDTH`: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `in_valid` in `NUM_CH`: per-channel word present
- `in_ready` out `NUM_CH`: per-channel accept; at most one bit high
- `selector` in `SEL_WIDTH`: requested channel in fixed mode
- `rr_mode` in 1: 0 = fixed (selector), 1 = round-robin
- `out_data` out `DATA_WIDTH`: FIFO head word
- `out_valid` out 1: FIFO not empty
- `out_ready` in 1: consumer accepts the head word
- `count` out `CNT_WIDTH`: FIFO occupancy, 0..`FIFO_DEPTH`

## Operation
- Registered `grant` (`SEL_WIDTH` bits) names the current channel.
- `in_ready[i]` = (`grant`==i) && !full. This is combinational from registers only and has no path from `in_valid` or `out_ready`.
- Push occurs when `in_valid[grant]` && `in_ready[grant]`. `in_data` slice `grant` is written at the tail.
- Pop occurs when `out_valid` && `out_ready`. The head advances.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- When full, there is no push, even if a pop occurs in the same cycle (no bypass).
- Pointers wrap modulo `FIFO_DEPTH`. Full = `count`==`FIFO_DEPTH`; empty = `count`==0.
- `out_data` = mem[rd_ptr] when non-empty. It is forced to 0 when empty.
- Fixed mode, next grant:
  - `selector` if `selector` < `NUM_CH`.
  - Otherwise `grant` holds.
- Round-robin mode, next grant:
  - If a push occurs this cycle, or `in_valid[grant]`==0: `grant` moves to the first channel with `in_valid` high, searching grant+1, grant+2, … cyclically and including `grant` itself last.
  - If no channel is valid, `grant` holds.
  - Otherwise `grant` holds.
- Result in round-robin mode: at most one word per channel before other requesters are served, with no starvation.
- Switching `rr_mode` takes effect on the next grant update. Queued data is unaffected.
- `rst` asserted asynchronously, including mid-transfer:
  - `grant`=0, pointers=0, `count`=0.
  - `out_valid`=0, `out_data`=0, `in_ready`=0.
  - FIFO contents are discarded.
- First cycle after `rst` deasserts: `in_ready[0]`=1 (FIFO empty, grant 0).

## Timing
- Input-to-output latency is 1 cycle. A word pushed at edge k is at the head with `out_valid`=1 after edge k when the FIFO was empty.
- Grant change latency is 1 cycle. A new `selector` value sampled at edge k drives `in_ready` after edge k.
- Throughput is 1 word/cycle with continuous `out_ready`=1 and a valid granted channel.
- In round-robin mode with all channels valid: one word per cycle, channels served 0,1,2,…,`NUM_CH`-1,0,…
- `count` and `out_valid` are registered and update on the same edge as the push/pop.
- `out_data` must remain stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset/idle check: assert `rst` mid-stream with 3 words queued. Required: `count`=0, `out_valid`=0, `out_data`=0 immediately without a clock edge; `in_ready`=4'b0001 after release.
- Fixed mode: `selector`=2, `in_valid`=4'b1111, ch2 data 0xA0..0xA5, `out_ready`=0.
  - After 4 pushes: `count`=4, `in_ready`=0.
  - Raise `out_ready`: outputs 0xA0,0xA1,… in order with no loss or duplication.
- Round-robin: `rr_mode`=1, all valid, `out_ready`=1, ch i data 0x10*i+n. Required output order 0x00,0x10,0x20,0x30,0x01,0x11,… at 1 word/cycle.
- Round-robin skip: only ch1 and ch3 valid. Required: grants alternate 1,3,1,3; ch0 and ch2 never receive `in_ready`.
- Full boundary: FIFO full, `out_ready`=1 and `in_valid[grant]`=1 in the same cycle. Required: pop only, `count`=3, then push on the next cycle (`count` returns to 4).
- Pointer wrap: 10 push/pop pairs through `FIFO_DEPTH`=4 with out-of-range `selector`=3 in a `NUM_CH`=3 build. Required: data order preserved across wraps; `grant` holds its previous value.
